// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address and registers
// each fetched word with its PC for decode. Handles stalls, redirects and halt.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000000C
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_valid,
  output logic                  o_halted,
  output logic [31:0]           o_fetch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  assign o_rom_addr = pc_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order inside this block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      o_instr     <= '0;
      o_pc        <= '0;
      o_valid     <= 1'b0;
      o_halted    <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            pc_q    <= RESET_PC;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (i_redirect) begin
            // Squash whatever is on the output; it came from the wrong path.
            pc_q    <= i_redirect_pc;
            o_valid <= 1'b0;
          end else if (!(i_stall && o_valid)) begin
            o_instr <= i_rom_data;
            o_pc    <= pc_q;
            o_valid <= 1'b1;
            if (o_fetch_cnt != 32'hFFFF_FFFF) begin
              o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            if (i_rom_data == HALT_INSTR) begin
              state_q  <= ST_HALT;
              o_halted <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end

        ST_HALT: begin
          if (i_start) begin
            pc_q     <= RESET_PC;
            o_halted <= 1'b0;
            o_valid  <= 1'b0;
            state_q  <= ST_FETCH;
          end else if (!i_stall) begin
            o_valid <= 1'b0;
          end
        end

        // NOTE: the unused encoding recovers to IDLE rather than locking up.
        default: begin
          state_q <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a spec-level model is compared against
// the DUT every cycle, and directed scenarios pin key values with literals.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] HALT = 32'h0000000C;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
  logic [31:0] i_rom_data;
  logic [15:0] o_rom_addr;
  logic [31:0] o_instr;
  logic [15:0] o_pc;
  logic        o_valid;
  logic        o_halted;
  logic [31:0] o_fetch_cnt;

  // ROM contents: every word is A5A5_<addr> except an optional HALT at halt_addr.
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = '0;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return HALT;
    return {16'hA5A5, a};
  endfunction

  assign i_rom_data = rom_word(o_rom_addr);

  instr_fetch_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_rom_data    (i_rom_data),
    .o_rom_addr    (o_rom_addr),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_fetch_cnt   (o_fetch_cnt)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: "running" means fetching, "stopped" means halted.
  typedef enum {M_IDLE, M_RUN, M_STOP} mode_t;
  mode_t       m_mode = M_IDLE;
  logic [15:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [15:0] m_opc = '0;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;
  longint      m_delivered = 0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_mode <= M_IDLE; m_pc <= 16'h0000; m_instr <= '0; m_opc <= '0;
      m_valid <= 1'b0; m_halted <= 1'b0; m_delivered <= 0;
    end else if (m_mode == M_IDLE) begin
      if (i_start) begin m_mode <= M_RUN; m_pc <= 16'h0000; end
    end else if (m_mode == M_STOP) begin
      if (i_start) begin
        m_mode <= M_RUN; m_pc <= 16'h0000; m_halted <= 1'b0; m_valid <= 1'b0;
      end else if (!i_stall) m_valid <= 1'b0;
    end else if (i_redirect) begin
      m_pc <= i_redirect_pc; m_valid <= 1'b0;
    end else if (!(i_stall && m_valid)) begin
      m_instr <= rom_word(m_pc); m_opc <= m_pc; m_valid <= 1'b1;
      m_delivered <= m_delivered + 1;
      if (rom_word(m_pc) == HALT) begin m_mode <= M_STOP; m_halted <= 1'b1; end
      else m_pc <= 16'((32'(m_pc) + 1) % 65536);
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge i_clk) begin
    if (cmp_en) begin
      logic [31:0] exp_cnt;
      exp_cnt = (m_delivered > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_delivered);
      check("model rom_addr", o_rom_addr, m_pc);
      check("model valid", o_valid, m_valid);
      check("model halted", o_halted, m_halted);
      check("model fetch_cnt", o_fetch_cnt, exp_cnt);
      check("model pc", o_pc, m_opc);
      check("model instr", o_instr, m_instr);
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic redirect_to(input logic [15:0] a);
    i_redirect = 1'b1; i_redirect_pc = a;
    tick();
    i_redirect = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [15:0] pc, input logic [31:0] instr);
    check({name, " valid"}, o_valid, 1'b1);
    check({name, " pc"}, o_pc, pc);
    check({name, " instr"}, o_instr, instr);
  endtask

  initial begin
    // Reset
    i_rst = 1'b1;
    tick(); tick();
    cmp_en = 1'b1;
    check("reset valid", o_valid, 1'b0);
    check("reset cnt", o_fetch_cnt, 32'd0);
    check("reset rom_addr", o_rom_addr, 16'h0000);
    i_rst = 1'b0;
    tick();
    check("idle valid", o_valid, 1'b0);

    // 1: straight-line fetch of words 0..6
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start edge valid", o_valid, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_word("seq", 16'(i), 32'hA5A5_0000 + 32'(i));
    end
    check("seq cnt", o_fetch_cnt, 32'd7);

    // i_start while fetching is ignored
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    expect_word("start ignored", 16'd7, 32'hA5A5_0007);

    // 2: stall while o_pc=2
    redirect_to(16'd2);
    check("redir valid", o_valid, 1'b0);
    tick();
    expect_word("pre-stall", 16'd2, 32'hA5A5_0002);
    check("pre-stall cnt", o_fetch_cnt, 32'd9);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("stall", 16'd2, 32'hA5A5_0002);
      check("stall rom_addr", o_rom_addr, 16'd3);
      check("stall cnt", o_fetch_cnt, 32'd9);
    end
    i_stall = 1'b0;
    tick();
    expect_word("post-stall", 16'd3, 32'hA5A5_0003);

    // A stall over a bubble does not block fetch
    redirect_to(16'd4);
    i_stall = 1'b1;
    tick();
    expect_word("bubble not held", 16'd4, 32'hA5A5_0004);
    tick();
    expect_word("held after bubble", 16'd4, 32'hA5A5_0004);
    i_stall = 1'b0;

    // 3: redirect together with stall while o_pc=1
    redirect_to(16'd1);
    tick();
    expect_word("at pc1", 16'd1, 32'hA5A5_0001);
    i_stall = 1'b1;
    redirect_to(16'd5);
    i_stall = 1'b0;
    check("redir+stall valid", o_valid, 1'b0);
    check("redir+stall rom_addr", o_rom_addr, 16'd5);
    tick();
    expect_word("after redirect", 16'd5, 32'hA5A5_0005);

    // 4: HALT at word 3
    halt_en = 1'b1; halt_addr = 16'd3;
    redirect_to(16'd3);
    i_stall = 1'b1;
    tick();
    expect_word("halt word", 16'd3, HALT);
    check("halted", o_halted, 1'b1);
    check("halt rom_addr", o_rom_addr, 16'd3);
    tick();
    check("halt stalled valid", o_valid, 1'b1);
    i_stall = 1'b0;
    tick();
    check("halt drop valid", o_valid, 1'b0);
    check("halt instr kept", o_instr, HALT);
    redirect_to(16'd9);
    check("halt redirect ignored", o_rom_addr, 16'd3);
    check("halt still halted", o_halted, 1'b1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart halted", o_halted, 1'b0);
    check("restart valid", o_valid, 1'b0);
    check("restart rom_addr", o_rom_addr, 16'h0000);
    tick(); tick(); tick();
    expect_word("resume", 16'd2, 32'hA5A5_0002);

    // Redirect coincident with HALT on the ROM: redirect wins
    check("halt on bus", i_rom_data, HALT);
    redirect_to(16'd10);
    halt_en = 1'b0;
    check("redir over halt", o_halted, 1'b0);
    check("redir over halt addr", o_rom_addr, 16'd10);
    tick();
    expect_word("after halt squash", 16'd10, 32'hA5A5_000A);

    // 5: PC wrap
    redirect_to(16'hFFFF);
    tick();
    expect_word("wrap top", 16'hFFFF, 32'hA5A5_FFFF);
    tick();
    expect_word("wrap zero", 16'h0000, 32'hA5A5_0000);

    // 6: reset during a stall
    i_stall = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    check("rst valid", o_valid, 1'b0);
    check("rst instr", o_instr, 32'd0);
    check("rst pc", o_pc, 16'd0);
    check("rst cnt", o_fetch_cnt, 32'd0);
    check("rst halted", o_halted, 1'b0);
    i_rst = 1'b0; i_stall = 1'b0;
    tick(); tick(); tick();
    check("idle no fetch", o_valid, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    expect_word("after reset start", 16'd0, 32'hA5A5_0000);
    check("after reset cnt", o_fetch_cnt, 32'd1);

    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
